mem_ctrl_access: RTL and testbench

Debug-side initiator for the controller memory port of the memory arbiter. Turns burst commands (read/write, imem/dmem, start address, length) from the PDU debug controller into word accesses on the cpu_ctrl_imem_*/cpu_ctrl_dmem_* buses. Operates only while the CPU is halted (cpu_global_en=0). Returns read data on a valid/ready stream.

---
 rtl/pdu_dbg_pkg.sv | 22 ++
 rtl/mem_ctrl_rd_timer.sv | 29 ++
 rtl/mem_ctrl_access.sv | 161 ++++++++++++++++
 tb/tb_mem_ctrl_access.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdu_dbg_pkg.sv
// Shared types and constants for the PDU debug memory-access path.
// Imported by the controller access block and its read-latency timer.
package pdu_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_RESP,
    ST_FINISH
  } state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam logic SEL_IMEM = 1'b0;
  localparam logic SEL_DMEM = 1'b1;

  localparam logic [31:0] ADDR_STEP = 32'd4;

endpackage

// File: rtl/mem_ctrl_rd_timer.sv
// Loadable down-counter that times the synchronous memory read latency.
// Loaded with RD_LATENCY-1 when a read is issued; o_zero marks rdata valid.
module mem_ctrl_rd_timer #(
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam logic [1:0] LOAD_VAL = 2'(RD_LATENCY - 1);

  logic [1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 2'd0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_dec && (r_count != 2'd0)) begin
      r_count <= r_count - 2'd1;
    end
  end

  assign o_zero = (r_count == 2'd0);

endmodule

// File: rtl/mem_ctrl_access.sv
// Debug-side burst initiator on the controller port of the imem/dmem arbiter.
// Runs word-by-word read/write bursts only while the CPU is halted.
import pdu_dbg_pkg::*;

module mem_ctrl_access #(
  parameter int RD_LATENCY = 1,
  parameter int LEN_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_global_en,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic             cmd_sel,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [31:0]      wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [31:0]      rd_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      cpu_ctrl_imem_addr,
  input  logic [31:0]      cpu_ctrl_imem_rdata,
  output logic [31:0]      cpu_ctrl_imem_wdata,
  output logic             cpu_ctrl_imem_we,
  output logic [31:0]      cpu_ctrl_dmem_addr,
  input  logic [31:0]      cpu_ctrl_dmem_rdata,
  output logic [31:0]      cpu_ctrl_dmem_wdata,
  output logic             cpu_ctrl_dmem_we
);

  state_t             r_state;
  state_t             w_next;
  logic               r_sel;
  logic [31:0]        r_addr;
  logic [LEN_W-1:0]   r_count;
  logic [31:0]        r_rdData;
  logic               r_rdValid;
  logic               r_err;

  logic               w_busyState;
  logic               w_abort;
  logic               w_cmdReady;
  logic               w_accept;
  logic               w_wrFire;
  logic               w_rdFire;
  logic               w_last;
  logic               w_timerZero;
  logic [31:0]        w_rdataSel;

  assign w_busyState = (r_state == ST_WRITE)    || (r_state == ST_RD_ISSUE) ||
                       (r_state == ST_RD_WAIT)  || (r_state == ST_RD_RESP);
  assign w_abort     = w_busyState && cpu_global_en;
  assign w_accept    = cmd_valid && w_cmdReady;
  assign w_last      = (r_count == '0);
  assign w_rdataSel  = (r_sel == SEL_DMEM) ? cpu_ctrl_dmem_rdata : cpu_ctrl_imem_rdata;

  mem_ctrl_rd_timer #(
    .RD_LATENCY(RD_LATENCY)
  ) u_rd_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (r_state == ST_RD_ISSUE),
    .i_dec  (r_state == ST_RD_WAIT),
    .o_zero (w_timerZero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Abort overrides every state action so a halted-CPU violation never touches memory.
  always_comb begin
    w_next     = r_state;
    w_cmdReady = 1'b0;
    w_wrFire   = 1'b0;
    w_rdFire   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cmdReady = !cpu_global_en && !rst;
        if (cmd_valid && w_cmdReady) begin
          w_next = (cmd_write == CMD_WRITE) ? ST_WRITE : ST_RD_ISSUE;
        end
      end
      ST_WRITE: begin
        w_wrFire = wr_valid && !cpu_global_en;
        if (w_wrFire && w_last) begin
          w_next = ST_FINISH;
        end
      end
      ST_RD_ISSUE: w_next = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (w_timerZero) begin
          w_next = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        w_rdFire = r_rdValid && rd_ready && !cpu_global_en;
        if (w_rdFire) begin
          w_next = w_last ? ST_FINISH : ST_RD_ISSUE;
        end
      end
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    if (w_abort) begin
      w_next = ST_FINISH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel     <= SEL_IMEM;
      r_addr    <= 32'd0;
      r_count   <= '0;
      r_rdData  <= 32'd0;
      r_rdValid <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_abort;
      if (w_accept) begin
        r_sel   <= cmd_sel;
        r_addr  <= cmd_addr & ~32'h3;
        r_count <= cmd_len;
      end else if ((w_wrFire || w_rdFire) && !w_last) begin
        r_addr  <= r_addr + ADDR_STEP;
        r_count <= r_count - LEN_W'(1);
      end
      if (w_abort || w_rdFire) begin
        r_rdValid <= 1'b0;
      end else if ((r_state == ST_RD_WAIT) && w_timerZero) begin
        r_rdData  <= w_rdataSel;
        r_rdValid <= 1'b1;
      end
    end
  end

  assign cmd_ready           = w_cmdReady;
  assign wr_ready            = w_wrFire;
  assign rd_valid            = r_rdValid;
  assign rd_data             = r_rdData;
  assign busy                = w_busyState;
  assign done                = (r_state == ST_FINISH);
  assign err                 = r_err;
  assign cpu_ctrl_imem_addr  = r_addr;
  assign cpu_ctrl_dmem_addr  = r_addr;
  assign cpu_ctrl_imem_wdata = wr_data;
  assign cpu_ctrl_dmem_wdata = wr_data;
  assign cpu_ctrl_imem_we    = w_wrFire && (r_sel == SEL_IMEM);
  assign cpu_ctrl_dmem_we    = w_wrFire && (r_sel == SEL_DMEM);

endmodule

// File: tb/tb_mem_ctrl_access.sv
// Directed bench for mem_ctrl_access: bursts, stalls, latency, abort, wrap and reset.
// Memories are modelled as registered address-derived patterns so every word is known.
module tb_mem_ctrl_access;

  localparam logic [31:0] IMEM_TAG = 32'hC0DE_0000;
  localparam logic [31:0] DMEM_TAG = 32'hD00D_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_global_en, cmd_valid, cmd_ready, cmd_write, cmd_sel;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready, rd_valid, rd_ready, busy, done, err;
  logic [31:0] wr_data, rd_data;
  logic [31:0] imemAddr, imemRdata, imemWdata, dmemAddr, dmemRdata, dmemWdata;
  logic        imemWe, dmemWe;

  logic        cmdValid3, cmdReady3, rdValid3, busy3, done3, err3, wrReady3;
  logic        imemWe3, dmemWe3;
  logic [31:0] cmdAddr3, rdData3, imemAddr3, imemRdata3, imemWdata3;
  logic [31:0] dmemAddr3, dmemRdata3, dmemWdata3;

  int          total = 0;
  int          bad = 0;
  int          imemWeCount = 0;
  int          doneCount = 0;
  logic [31:0] wrAddrQ[$];
  logic [31:0] wrDataQ[$];

  always #5 clk = ~clk;

  mem_ctrl_access #(.RD_LATENCY(1), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .cpu_global_en(cpu_global_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err),
    .cpu_ctrl_imem_addr(imemAddr), .cpu_ctrl_imem_rdata(imemRdata),
    .cpu_ctrl_imem_wdata(imemWdata), .cpu_ctrl_imem_we(imemWe),
    .cpu_ctrl_dmem_addr(dmemAddr), .cpu_ctrl_dmem_rdata(dmemRdata),
    .cpu_ctrl_dmem_wdata(dmemWdata), .cpu_ctrl_dmem_we(dmemWe)
  );

  mem_ctrl_access #(.RD_LATENCY(3), .LEN_W(8)) dut3 (
    .clk(clk), .rst(rst), .cpu_global_en(1'b0),
    .cmd_valid(cmdValid3), .cmd_ready(cmdReady3), .cmd_write(1'b0),
    .cmd_sel(1'b1), .cmd_addr(cmdAddr3), .cmd_len(8'd0),
    .wr_valid(1'b0), .wr_ready(wrReady3), .wr_data(32'd0),
    .rd_valid(rdValid3), .rd_ready(1'b1), .rd_data(rdData3),
    .busy(busy3), .done(done3), .err(err3),
    .cpu_ctrl_imem_addr(imemAddr3), .cpu_ctrl_imem_rdata(imemRdata3),
    .cpu_ctrl_imem_wdata(imemWdata3), .cpu_ctrl_imem_we(imemWe3),
    .cpu_ctrl_dmem_addr(dmemAddr3), .cpu_ctrl_dmem_rdata(dmemRdata3),
    .cpu_ctrl_dmem_wdata(dmemWdata3), .cpu_ctrl_dmem_we(dmemWe3)
  );

  always @(posedge clk) begin
    imemRdata  <= imemAddr ^ IMEM_TAG;
    dmemRdata  <= dmemAddr ^ DMEM_TAG;
    imemRdata3 <= imemAddr3 ^ IMEM_TAG;
    dmemRdata3 <= dmemAddr3 ^ DMEM_TAG;
  end

  // Observe memory-side strobes just before each rising edge, once inputs have settled.
  always @(negedge clk) begin
    #4;
    if (!rst) begin
      if (dmemWe) begin
        wrAddrQ.push_back(dmemAddr);
        wrDataQ.push_back(dmemWdata);
      end
      if (imemWe) imemWeCount++;
      if (done) doneCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic isWrite, input logic sel,
                               input logic [31:0] addr, input logic [7:0] len);
    logic ready;
    logic accepted = 1'b0;
    @(negedge clk);
    cmd_write = isWrite; cmd_sel = sel; cmd_addr = addr; cmd_len = len;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      #1 ready = cmd_ready;
      @(posedge clk);
      if (ready) accepted = 1'b1;
      else @(negedge clk);
    end
    #1 cmd_valid = 1'b0;
    if (!accepted) checkOutput("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic pushWord(input logic [31:0] data, input int gap);
    logic ready;
    logic taken = 1'b0;
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (gap) @(negedge clk);
    wr_data = data; wr_valid = 1'b1;
    for (int i = 0; i < 20 && !taken; i++) begin
      #1 ready = wr_ready;
      @(posedge clk);
      if (ready) taken = 1'b1;
      else @(negedge clk);
    end
    #1 wr_valid = 1'b0;
    if (!taken) checkOutput("wr_handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitRdValid(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1 seen = rd_valid;
    end
    if (!seen) checkOutput(tag, 32'd0, 32'd1);
  endtask

  task automatic consumeRead();
    rd_ready = 1'b1;
    @(posedge clk);
    #1 rd_ready = 1'b0;
  endtask

  task automatic waitDone(input string tag, input logic expErr);
    logic seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1 seen = done;
    end
    if (!seen) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    else begin
      checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, expErr});
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int doneStart;
    int lat;
    rst = 1'b1; cpu_global_en = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_sel = 1'b0; cmd_addr = 32'd0; cmd_len = 8'd0; wr_valid = 1'b0;
    wr_data = 32'd0; rd_ready = 1'b0; cmdValid3 = 1'b0; cmdAddr3 = 32'd0;
    #1;
    checkOutput("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_rd_data", rd_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Write burst to dmem with gaps between words.
    wrAddrQ.delete(); wrDataQ.delete();
    applyStimulus(1'b1, 1'b1, 32'h100, 8'd2);
    checkOutput("wr_busy", {31'd0, busy}, 32'd1);
    pushWord(32'hA, 2);
    pushWord(32'hB, 0);
    pushWord(32'hC, 3);
    waitDone("wr_done", 1'b0);
    checkOutput("wr_count", wrAddrQ.size(), 32'd3);
    if (wrAddrQ.size() == 3) begin
      checkOutput("wr0_addr", wrAddrQ[0], 32'h100);
      checkOutput("wr0_data", wrDataQ[0], 32'hA);
      checkOutput("wr1_addr", wrAddrQ[1], 32'h104);
      checkOutput("wr1_data", wrDataQ[1], 32'hB);
      checkOutput("wr2_addr", wrAddrQ[2], 32'h108);
      checkOutput("wr2_data", wrDataQ[2], 32'hC);
    end
    @(negedge clk);
    wr_valid = 1'b1;
    #1 checkOutput("idle_wr_ready", {31'd0, wr_ready}, 32'd0);
    checkOutput("idle_dmem_we", {31'd0, dmemWe}, 32'd0);
    wr_valid = 1'b0;

    // Read imem with a stalled consumer.
    doneStart = doneCount;
    applyStimulus(1'b0, 1'b0, 32'h0, 8'd1);
    waitRdValid("rd0_valid_timeout");
    checkOutput("rd0_data", rd_data, 32'hC0DE_0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 checkOutput("rd0_stall_valid", {31'd0, rd_valid}, 32'd1);
      checkOutput("rd0_stall_data", rd_data, 32'hC0DE_0000);
    end
    consumeRead();
    checkOutput("rd0_valid_drop", {31'd0, rd_valid}, 32'd0);
    waitRdValid("rd1_valid_timeout");
    checkOutput("rd1_data", rd_data, 32'hC0DE_0004);
    checkOutput("rd1_addr", imemAddr, 32'h4);
    consumeRead();
    waitDone("rd_done", 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rd_done_once", doneCount - doneStart, 32'd1);

    // Read latency 3: rd_valid four edges after the accepting edge.
    @(negedge clk);
    cmdAddr3 = 32'h40; cmdValid3 = 1'b1;
    #1 checkOutput("lat3_cmd_ready", {31'd0, cmdReady3}, 32'd1);
    @(posedge clk);
    #1 cmdValid3 = 1'b0;
    lat = -1;
    for (int k = 0; k < 12 && lat < 0; k++) begin
      @(negedge clk);
      if (rdValid3) begin
        lat = k;
        checkOutput("lat3_data", rdData3, 32'hD00D_0040);
      end
    end
    checkOutput("lat3_cycles", lat, 32'd4);

    // Halted-CPU gating at accept, then abort after two of four writes.
    wrAddrQ.delete(); wrDataQ.delete();
    @(negedge clk);
    cpu_global_en = 1'b1;
    cmd_write = 1'b1; cmd_sel = 1'b1; cmd_addr = 32'h200; cmd_len = 8'd3;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("gated_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      checkOutput("gated_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
    end
    cpu_global_en = 1'b0;
    #1 checkOutput("ungated_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 32'd1);
    pushWord(32'h11, 0);
    pushWord(32'h22, 1);
    @(negedge clk);
    cpu_global_en = 1'b1; wr_data = 32'h33; wr_valid = 1'b1;
    #1 checkOutput("abort_wr_ready", {31'd0, wr_ready}, 32'd0);
    @(negedge clk);
    #1 checkOutput("abort_done", {31'd0, done}, 32'd1);
    checkOutput("abort_err", {31'd0, err}, 32'd1);
    checkOutput("abort_busy_low", {31'd0, busy}, 32'd0);
    wr_valid = 1'b0; cpu_global_en = 1'b0;
    @(negedge clk);
    #1 checkOutput("abort_err_pulse", {31'd0, err}, 32'd0);
    checkOutput("abort_wr_count", wrAddrQ.size(), 32'd2);
    if (wrAddrQ.size() == 2) begin
      checkOutput("abort_wr1_addr", wrAddrQ[1], 32'h204);
      checkOutput("abort_wr1_data", wrDataQ[1], 32'h22);
    end

    // Address wrap from the top of the space, misaligned start forced aligned.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE, 8'd1);
    waitRdValid("wrap0_valid_timeout");
    checkOutput("wrap0_addr", dmemAddr, 32'hFFFF_FFFC);
    checkOutput("wrap0_data", rd_data, 32'h2FF2_FFFC);
    consumeRead();
    waitRdValid("wrap1_valid_timeout");
    checkOutput("wrap1_addr", dmemAddr, 32'h0);
    checkOutput("wrap1_data", rd_data, 32'hD00D_0000);
    consumeRead();
    waitDone("wrap_done", 1'b0);

    // Asynchronous reset in the middle of a read burst.
    applyStimulus(1'b0, 1'b1, 32'h300, 8'd5);
    waitRdValid("rst_valid_timeout");
    checkOutput("rst_pre_data", rd_data, 32'hD00D_0300);
    rst = 1'b1;
    #1 checkOutput("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    checkOutput("rst_rd_data", rd_data, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_addr", dmemAddr, 32'd0);
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    checkOutput("imem_we_never", imemWeCount, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
